// File: rtl/ccff_ctrl_pkg.sv
// ============================================================================
// ccff_ctrl_pkg : shared state encoding and word-count helpers for the
//                 configuration-chain loader.
// Revision      : 1.0
// ============================================================================
`default_nettype none

package ccff_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_RB_PUSH = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    function automatic int nwords(input int chain_len, input int dw);
        return (chain_len + dw - 1) / dw;
    endfunction

    // Valid bits carried by the final word; a full word when the chain divides evenly.
    function automatic int last_bits(input int chain_len, input int dw);
        return ((chain_len % dw) == 0) ? dw : (chain_len % dw);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ccff_word_shifter.sv
// ============================================================================
// ccff_word_shifter : parallel-load/serial-out config shifter and serial-in
//                     read-back register with left-aligned output.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module ccff_word_shifter #(
    parameter int DW = 8,
    parameter int BW = $clog2(DW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] data,
    input  logic          shift,
    input  logic          tail,
    input  logic [BW-1:0] nbits,
    output logic          head,
    output logic [DW-1:0] rb_data
);

    logic [DW-1:0] shreg;
    logic [DW-1:0] rbreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            rbreg <= '0;
        end else if (load) begin
            shreg <= data;
            rbreg <= '0;
        end else if (shift) begin
            shreg <= shreg << 1;
            rbreg <= (rbreg << 1) | DW'(tail);
        end
    end

    // Head is the shift register MSB itself, so the chain input is flop-driven.
    assign head = shreg[DW-1];

    // Captured bits sit in the low nbits positions; move them to the top, zero below.
    assign rb_data = rbreg << (DW - int'(nbits));

endmodule

`default_nettype wire

// File: rtl/ccff_chain_loader.sv
// ============================================================================
// ccff_chain_loader : streams configuration words MSB-first into a tile's
//                     ccff chain and returns the displaced chain contents.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module ccff_chain_loader
    import ccff_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 32,
    parameter int DW        = 8
) (
    input  logic          prog_clk,
    input  logic          pReset,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] cfg_data,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    output logic          ccff_head,
    output logic          ccff_shift_en,
    input  logic          ccff_tail,
    output logic [DW-1:0] rb_data,
    output logic          rb_valid,
    input  logic          rb_ready,
    output logic          busy,
    output logic          done
);

    localparam int TW   = $clog2(CHAIN_LEN + 1);
    localparam int BW   = $clog2(DW + 1);
    localparam int LAST = last_bits(CHAIN_LEN, DW);

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] total;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] nbits;
    logic          shift_en_q;
    logic          shifting;
    logic          last_bit;
    logic          load;

    assign shifting = (state == ST_SHIFT);
    assign last_bit = shifting && ((bit_cnt + BW'(1)) == nbits);
    assign load     = (state == ST_FETCH) && cfg_valid && !abort;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (start)     state_nx = ST_FETCH;
            ST_FETCH:   if (cfg_valid) state_nx = ST_SHIFT;
            ST_SHIFT:   if (last_bit)  state_nx = ST_RB_PUSH;
            ST_RB_PUSH: if (rb_ready)  state_nx = (total == TW'(CHAIN_LEN)) ? ST_DONE : ST_FETCH;
            ST_DONE:                   state_nx = ST_IDLE;
            default:                   state_nx = ST_IDLE;
        endcase
        // Abort overrides every other transition once a load is under way.
        if (abort && (state != ST_IDLE)) begin
            state_nx = ST_IDLE;
        end
    end

    always_comb begin
        cfg_ready = (state == ST_FETCH);
        rb_valid  = (state == ST_RB_PUSH);
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
    end

    // Shift enable is registered from the next state so the tile clock gate sees a clean flop.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            total      <= '0;
            bit_cnt    <= '0;
            nbits      <= '0;
            shift_en_q <= 1'b0;
        end else begin
            shift_en_q <= (state_nx == ST_SHIFT);
            if (state == ST_IDLE) begin
                total <= '0;
            end else if (shifting) begin
                total <= total + TW'(1);
            end
            if (load) begin
                bit_cnt <= '0;
                nbits   <= ((CHAIN_LEN - int'(total)) > DW) ? BW'(DW) : BW'(LAST);
            end else if (shifting) begin
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

    assign ccff_shift_en = shift_en_q;

    ccff_word_shifter #(
        .DW (DW),
        .BW (BW)
    ) u_shifter (
        .clk     (prog_clk),
        .rst     (pReset),
        .load    (load),
        .data    (cfg_data),
        .shift   (shifting),
        .tail    (ccff_tail),
        .nbits   (nbits),
        .head    (ccff_head),
        .rb_data (rb_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
// ============================================================================
// tb_ccff_chain_loader : directed bench with reference chain models and a
//                        read-back scoreboard for the chain loader.
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_ccff_chain_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit chain instance
    logic        rst_a, start_a, abort_a, cfg_valid_a, rb_ready_a, tail_a;
    logic [7:0]  cfg_data_a, rb_data_a;
    logic        cfg_ready_a, head_a, sen_a, rb_valid_a, busy_a, done_a;

    // 20-bit chain instance
    logic        rst_b, start_b, abort_b, cfg_valid_b, rb_ready_b, tail_b;
    logic [7:0]  cfg_data_b, rb_data_b;
    logic        cfg_ready_b, head_b, sen_b, rb_valid_b, busy_b, done_b;

    ccff_chain_loader #(.CHAIN_LEN(32), .DW(8)) dut_a (
        .prog_clk(clk), .pReset(rst_a), .start(start_a), .abort(abort_a),
        .cfg_data(cfg_data_a), .cfg_valid(cfg_valid_a), .cfg_ready(cfg_ready_a),
        .ccff_head(head_a), .ccff_shift_en(sen_a), .ccff_tail(tail_a),
        .rb_data(rb_data_a), .rb_valid(rb_valid_a), .rb_ready(rb_ready_a),
        .busy(busy_a), .done(done_a)
    );

    ccff_chain_loader #(.CHAIN_LEN(20), .DW(8)) dut_b (
        .prog_clk(clk), .pReset(rst_b), .start(start_b), .abort(abort_b),
        .cfg_data(cfg_data_b), .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
        .ccff_head(head_b), .ccff_shift_en(sen_b), .ccff_tail(tail_b),
        .rb_data(rb_data_b), .rb_valid(rb_valid_b), .rb_ready(rb_ready_b),
        .busy(busy_b), .done(done_b)
    );

    // Reference chains: shift on every enabled edge, logging what entered at the head.
    logic [31:0] chain_a, hlog_a, pre_val_a;
    logic [19:0] chain_b, hlog_b, pre_val_b;
    int          shifts_a, shifts_b;
    logic        pre_a = 1'b0, pre_b = 1'b0;

    assign tail_a = chain_a[31];
    assign tail_b = chain_b[19];

    always @(posedge clk) begin
        if (pre_a) begin
            chain_a <= pre_val_a; hlog_a <= '0; shifts_a <= 0;
        end else if (sen_a) begin
            chain_a <= {chain_a[30:0], head_a}; hlog_a <= {hlog_a[30:0], head_a}; shifts_a <= shifts_a + 1;
        end
        if (pre_b) begin
            chain_b <= pre_val_b; hlog_b <= '0; shifts_b <= 0;
        end else if (sen_b) begin
            chain_b <= {chain_b[18:0], head_b}; hlog_b <= {hlog_b[18:0], head_b}; shifts_b <= shifts_b + 1;
        end
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  exp_q[$];

    // Scenario knobs for load_a
    logic [31:0] words_a;
    int          gap_word, gap_len, stall_word, stall_len, abort_word, rst_word, start_mid_cyc, exp_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic defaults();
        words_a = 32'hA53CFF01;
        gap_word = -1; gap_len = 0; stall_word = -1; stall_len = 0;
        abort_word = -1; rst_word = -1; start_mid_cyc = -1; exp_done = 41;
    endtask

    task automatic preload_a(input logic [31:0] v);
        pre_val_a = v; pre_a = 1'b1;
        @(negedge clk);
        pre_a = 1'b0;
    endtask

    task automatic load_a(input string name);
        int         cyc, wi, ri, sc, gap, stall, done_cyc;
        logic       ended;
        logic [7:0] expw;
        wi = 0; ri = 0; sc = 0; gap = gap_len; stall = stall_len; done_cyc = -1; ended = 1'b0;
        exp_q.delete();
        @(negedge clk);
        start_a = 1'b1;
        cyc = 0;
        while (!ended && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start_a = (cyc == start_mid_cyc);
            abort_a = 1'b0; cfg_valid_a = 1'b0; rb_ready_a = 1'b0; rst_a = 1'b0;
            if (cyc == 1) check({name, " cfg_ready@1"}, 32'(cfg_ready_a), 32'd1);
            if (cfg_ready_a) begin
                if (wi == gap_word && gap > 0) begin
                    check({name, " shift_en in fetch stall"}, 32'(sen_a), 32'd0);
                    gap--;
                end else begin
                    cfg_valid_a = 1'b1;
                    cfg_data_a  = words_a[31-8*wi -: 8];
                    exp_q.push_back(pre_val_a[31-8*wi -: 8]);
                    wi++;
                    sc = 0;
                end
            end
            if (sen_a) begin
                sc++;
                if (wi - 1 == abort_word && sc == 4) begin
                    abort_a = 1'b1;
                    @(negedge clk);
                    abort_a = 1'b0;
                    check({name, " busy after abort"}, 32'(busy_a), 32'd0);
                    check({name, " shift_en after abort"}, 32'(sen_a), 32'd0);
                    check({name, " rb_valid after abort"}, 32'(rb_valid_a), 32'd0);
                    check({name, " done after abort"}, 32'(done_a), 32'd0);
                    ended = 1'b1;
                end
            end
            if (rb_valid_a && !ended) begin
                if (ri == rst_word) begin
                    rst_a = 1'b1;
                    @(negedge clk);
                    rst_a = 1'b0;
                    check({name, " outputs after reset"},
                          32'({cfg_ready_a, head_a, sen_a, rb_valid_a, rb_data_a, busy_a, done_a}), 32'd0);
                    ended = 1'b1;
                end else if (ri == stall_word && stall > 0) begin
                    check({name, " rb_data held in stall"}, 32'(rb_data_a), 32'(exp_q[0]));
                    check({name, " shift_en in rb stall"}, 32'(sen_a), 32'd0);
                    stall--;
                end else begin
                    rb_ready_a = 1'b1;
                    expw = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    check($sformatf("%s rb word %0d", name, ri), 32'(rb_data_a), 32'(expw));
                    ri++;
                end
            end
            if (done_a) begin
                done_cyc = cyc;
                ended = 1'b1;
            end
        end
        start_a = 1'b0; cfg_valid_a = 1'b0; rb_ready_a = 1'b0; abort_a = 1'b0; rst_a = 1'b0;
        check({name, " finished within budget"}, 32'(ended), 32'd1);
        if (exp_done >= 0) begin
            check({name, " done cycle"}, done_cyc, exp_done);
            @(negedge clk);
            check({name, " done single pulse"}, 32'(done_a), 32'd0);
            check({name, " idle after done"}, 32'(busy_a), 32'd0);
            check({name, " head sequence"}, hlog_a, words_a);
            check({name, " chain content"}, chain_a, words_a);
            check({name, " shift count"}, shifts_a, 32);
            check({name, " scoreboard empty"}, exp_q.size(), 0);
        end
    endtask

    initial begin
        int         cyc, wi, ri, done_cyc;
        logic [7:0] expw;
        logic [23:0] words_b;

        rst_a = 1'b1; start_a = 1'b0; abort_a = 1'b0; cfg_valid_a = 1'b0; rb_ready_a = 1'b0; cfg_data_a = '0;
        rst_b = 1'b1; start_b = 1'b0; abort_b = 1'b0; cfg_valid_b = 1'b0; rb_ready_b = 1'b0; cfg_data_b = '0;
        defaults();
        pre_val_b = 20'hABCDE; pre_b = 1'b1;
        preload_a(32'hDEADBEEF);
        pre_b = 1'b0;
        @(negedge clk);
        check("reset outputs a",
              32'({cfg_ready_a, head_a, sen_a, rb_valid_a, rb_data_a, busy_a, done_a}), 32'd0);
        check("reset outputs b",
              32'({cfg_ready_b, head_b, sen_b, rb_valid_b, rb_data_b, busy_b, done_b}), 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // Scenario 1: straight load
        load_a("s1");

        // Scenario 2: 20-bit chain, partial final word
        words_b = 24'h12345F;
        exp_q.delete();
        exp_q.push_back(8'hAB); exp_q.push_back(8'hCD); exp_q.push_back(8'hE0);
        rb_ready_b = 1'b1;
        start_b = 1'b1;
        cyc = 0; wi = 0; ri = 0; done_cyc = -1;
        while (done_cyc < 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start_b = 1'b0;
            cfg_valid_b = 1'b0;
            if (cfg_ready_b) begin
                cfg_valid_b = 1'b1;
                cfg_data_b  = words_b[23-8*wi -: 8];
                wi++;
            end
            if (rb_valid_b) begin
                expw = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                check($sformatf("s2 rb word %0d", ri), 32'(rb_data_b), 32'(expw));
                ri++;
            end
            if (done_b) done_cyc = cyc;
        end
        cfg_valid_b = 1'b0; rb_ready_b = 1'b0;
        check("s2 done cycle", done_cyc, 27);
        check("s2 shift count", shifts_b, 20);
        check("s2 head sequence", 32'(hlog_b), 32'h12345);
        check("s2 chain content", 32'(chain_b), 32'h12345);
        @(negedge clk);

        // Scenario 3: fetch gap before word 2, read-back stall on word 1
        defaults();
        preload_a(32'hDEADBEEF);
        gap_word = 1; gap_len = 5; stall_word = 0; stall_len = 3; exp_done = 49;
        load_a("s3");

        // Scenario 4: abort on the 4th shift of word 2, then a clean load
        defaults();
        preload_a(32'h12345678);
        abort_word = 1; exp_done = -1;
        load_a("s4 abort");
        defaults();
        preload_a(32'hDEADBEEF);
        load_a("s4 reload");

        // Scenario 5: stray start mid-load, reset during read-back of word 2, then a clean load
        defaults();
        preload_a(32'hCAFEF00D);
        start_mid_cyc = 3; rst_word = 1; exp_done = -1;
        load_a("s5 reset");
        defaults();
        preload_a(32'hDEADBEEF);
        load_a("s5 reload");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
